lcd_bus_ctrl: RTL and testbench
===============================

LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 Parameter BUS_WIDTH, default 4: LCD data bus width; legal values 4 or 8.
REQ-002 Parameter SETUP_CYC, default 2: cycles rs/rw/dataout are stable before enable rises; minimum 1.
REQ-003 Parameter PULSE_CYC, default 4: enable-high cycles per bus transfer; minimum 1.
REQ-004 Parameter HOLD_CYC, default 2: cycles rs/rw/dataout are held after enable falls; minimum 1.
REQ-005 Parameter GAP_CYC, default 3: idle settle cycles after the last transfer of a byte; minimum 0.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  request; accepted only on a cycle where ready=1.
REQ-010 ready  out  1  high when idle and able to accept.
REQ-011 rs  in  1  register select, captured on acceptance.
REQ-012 rw  in  1  read/write select, captured on acceptance; 1=read.
REQ-013 datain  in  8  write byte, captured on acceptance.
REQ-014 rs_out, rw_out  out  1 each  LCD RS and RW pins.
REQ-015 enable  out  1  LCD E strobe.
REQ-016 dataout  out  BUS_WIDTH  LCD data pins (drive side).
REQ-017 lcd_din  in  BUS_WIDTH  LCD data pins (sample side).
REQ-018 rdata  out  8  last read byte; rdata_valid  out  1  one-cycle strobe.

Function
REQ-019 States: IDLE, SETUP, PULSE, HOLD, GAP; ready=1 only in IDLE.
REQ-020 On the edge where start=1 and ready=1, rs/rw/datain SHALL be captured and the state SHALL move to SETUP; later changes on these inputs SHALL be ignored until the byte completes.
REQ-021 start while ready=0 SHALL be ignored, not queued.
REQ-022 SETUP lasts SETUP_CYC, PULSE lasts PULSE_CYC, and HOLD lasts HOLD_CYC cycles; enable=1 exactly during PULSE.
REQ-023 All outputs SHALL be registered; rs_out and rw_out SHALL be constant from the first SETUP cycle to the last HOLD cycle of the byte.
REQ-024 BUS_WIDTH=4: first transfer SHALL drive datain[7:4]. After HOLD the FSM SHALL return to SETUP for a second transfer driving datain[3:0].
REQ-025 BUS_WIDTH=8: one transfer SHALL drive datain[7:0].
REQ-026 After the final HOLD the FSM SHALL enter GAP for GAP_CYC cycles, skipped when 0, then enter IDLE.
REQ-027 Busy time, ready=0, SHALL be exactly N*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+GAP_CYC cycles, with N=2 for a 4-bit bus and N=1 for an 8-bit bus.
REQ-028 Back-to-back: start held high SHALL be accepted on the first IDLE cycle, giving one ready-high cycle between bytes.
REQ-029 In IDLE, enable SHALL be 0 and dataout, rs_out and rw_out SHALL hold their last driven values.
REQ-030 The timing counter SHALL be wide enough for max(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC) and SHALL never wrap mid-phase.

Reset
REQ-031 rst SHALL immediately force IDLE, ready=1, and enable, rs_out, rw_out, dataout, rdata and rdata_valid to 0, including mid-PULSE.
REQ-032 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-033 With LCD_READBACK_EN defined, a request with rw=1 SHALL sample lcd_din on the last PULSE cycle of each transfer. In 4-bit mode the first sample SHALL fill rdata[7:4] and the second rdata[3:0]. rdata_valid SHALL pulse for 1 cycle on entry to GAP, or to IDLE when GAP_CYC=0.
REQ-034 Without LCD_READBACK_EN, rw SHALL be ignored, rw_out SHALL be 0, lcd_din SHALL be unused, and rdata and rdata_valid SHALL be tied to 0.

Structure
REQ-035 The package lcd_pkg SHALL hold the state encoding and the default timing constants.
REQ-036 Phase timing SHALL use one sub-module, lcd_phase_timer: a loadable down-counter with a done flag.

Verification
REQ-037 Defaults, start with rs=1, rw=0, datain=0xA5: dataout=0xA for 4 enable-high cycles, then 0x5 for 4; rs_out=1; ready low for 19 cycles.
REQ-038 BUS_WIDTH=8, datain=0x3C: one 4-cycle enable pulse with dataout=0x3C; ready low for 11 cycles.
REQ-039 Start held high for 3 bytes (0x01, 0x02, 0x03): each accepted exactly once; ready high for exactly 1 cycle between bytes.
REQ-040 Assert rst on the 2nd enable-high cycle of the first nibble: enable=0 the same cycle; ready=1; a following start 0x55 completes correctly.
REQ-041 LCD_READBACK_EN, rw=1, lcd_din=0x9 then 0x6: rdata=0x96 with a single rdata_valid pulse; rw_out=1 throughout.
REQ-042 Toggle datain and start while ready=0: no effect on the bus; busy count unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state encoding, default phase timing and a sizing helper for the LCD bus controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GAP
  } lcd_state_t;

  localparam int LCD_BUS_WIDTH_DEF = 4;
  localparam int LCD_SETUP_CYC_DEF = 2;
  localparam int LCD_PULSE_CYC_DEF = 4;
  localparam int LCD_HOLD_CYC_DEF  = 2;
  localparam int LCD_GAP_CYC_DEF   = 3;

  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter: counts a phase length down to zero and flags completion.
module lcd_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so an idle timer never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style LCD bus sequencer: setup / enable pulse / hold per transfer, optional settle gap.
// Define LCD_READBACK_EN to sample lcd_din on read requests and report rdata/rdata_valid.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH = LCD_BUS_WIDTH_DEF,
  parameter int SETUP_CYC = LCD_SETUP_CYC_DEF,
  parameter int PULSE_CYC = LCD_PULSE_CYC_DEF,
  parameter int HOLD_CYC  = LCD_HOLD_CYC_DEF,
  parameter int GAP_CYC   = LCD_GAP_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  input  logic                 rs,
  input  logic                 rw,
  input  logic [7:0]           datain,
  output logic                 rs_out,
  output logic                 rw_out,
  output logic                 enable,
  output logic [BUS_WIDTH-1:0] dataout,
  input  logic [BUS_WIDTH-1:0] lcd_din,
  output logic [7:0]           rdata,
  output logic                 rdata_valid
);

  localparam int MAX_CYC = lcd_max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam bit NIBBLE = (BUS_WIDTH == 4);

  lcd_state_t r_state, w_state_n;

  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;
  logic             w_accept;
  logic             w_next_xfer;
  logic             w_final;
  logic             w_last_pulse;

  logic                 r_ready;
  logic                 r_enable;
  logic                 r_rs;
  logic [BUS_WIDTH-1:0] r_dout;
  logic                 r_second;
  logic [3:0]           r_lo_nib;

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Every phase change reloads the timer with the next phase length minus one.
  always_comb begin
    w_state_n   = r_state;
    w_load      = 1'b0;
    w_load_val  = SETUP_LD;
    w_accept    = 1'b0;
    w_next_xfer = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n = ST_SETUP;
          w_load    = 1'b1;
          w_accept  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_state_n  = ST_PULSE;
          w_load     = 1'b1;
          w_load_val = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (w_done) begin
          w_state_n  = ST_HOLD;
          w_load     = 1'b1;
          w_load_val = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (w_done) begin
          if (NIBBLE && !r_second) begin
            w_state_n   = ST_SETUP;
            w_load      = 1'b1;
            w_next_xfer = 1'b1;
          end else begin
            w_final = 1'b1;
            if (GAP_CYC > 0) begin
              w_state_n  = ST_GAP;
              w_load     = 1'b1;
              w_load_val = GAP_LD;
            end else begin
              w_state_n = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (w_done) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign w_last_pulse = (r_state == ST_PULSE) && w_done;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_enable <= 1'b0;
      r_rs     <= 1'b0;
      r_dout   <= '0;
      r_second <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_ready  <= (w_state_n == ST_IDLE);
      r_enable <= (w_state_n == ST_PULSE);
      if (w_accept) begin
        r_rs     <= rs;
        r_second <= 1'b0;
        r_dout   <= NIBBLE ? BUS_WIDTH'(datain[7:4]) : BUS_WIDTH'(datain);
      end else if (w_next_xfer) begin
        r_second <= 1'b1;
        r_dout   <= BUS_WIDTH'(r_lo_nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_lo_nib <= datain[3:0];
  end

  assign ready   = r_ready;
  assign enable  = r_enable;
  assign rs_out  = r_rs;
  assign dataout = r_dout;

`ifdef LCD_READBACK_EN
  logic       r_rw;
  logic [7:0] r_rdata;
  logic       r_rvalid;

  // The bus is sampled at the end of the enable pulse, when the LCD output is settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw     <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_final && r_rw;
      if (w_accept) r_rw <= rw;
      if (w_last_pulse && r_rw) begin
        if (!NIBBLE) begin
          r_rdata <= 8'(lcd_din);
        end else if (!r_second) begin
          r_rdata[7:4] <= lcd_din[3:0];
        end else begin
          r_rdata[3:0] <= lcd_din[3:0];
        end
      end
    end
  end

  assign rw_out      = r_rw;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rvalid;
`else
  logic w_unused_rb;
  assign w_unused_rb = ^{rw, lcd_din, w_last_pulse, w_final};

  assign rw_out      = 1'b0;
  assign rdata       = '0;
  assign rdata_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: three instances (4-bit default, 8-bit, 4-bit minimum timing / no gap).
module tb_lcd_bus_ctrl;

`ifdef LCD_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, rs, rw;
  logic [7:0] datain;
  int         sel;

  logic       st_a, st_b, st_c;
  logic [3:0] din_a, din_c;
  logic [7:0] din_b;
  logic       rdy_a, rdy_b, rdy_c, rso_a, rso_b, rso_c, rwo_a, rwo_b, rwo_c;
  logic       en_a, en_b, en_c, rv_a, rv_b, rv_c;
  logic [3:0] dout_a, dout_c;
  logic [7:0] dout_b, rd_a, rd_b, rd_c;

  logic       o_ready, o_rs, o_rw, o_en, o_rv;
  logic [7:0] o_dout, o_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign st_a = start && (sel == 0);
  assign st_b = start && (sel == 1);
  assign st_c = start && (sel == 2);

  lcd_bus_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(st_a), .ready(rdy_a), .rs(rs), .rw(rw), .datain(datain),
    .rs_out(rso_a), .rw_out(rwo_a), .enable(en_a), .dataout(dout_a), .lcd_din(din_a),
    .rdata(rd_a), .rdata_valid(rv_a)
  );

  lcd_bus_ctrl #(.BUS_WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(st_b), .ready(rdy_b), .rs(rs), .rw(rw), .datain(datain),
    .rs_out(rso_b), .rw_out(rwo_b), .enable(en_b), .dataout(dout_b), .lcd_din(din_b),
    .rdata(rd_b), .rdata_valid(rv_b)
  );

  lcd_bus_ctrl #(.BUS_WIDTH(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .GAP_CYC(0)) u_dut_c (
    .clk(clk), .rst(rst), .start(st_c), .ready(rdy_c), .rs(rs), .rw(rw), .datain(datain),
    .rs_out(rso_c), .rw_out(rwo_c), .enable(en_c), .dataout(dout_c), .lcd_din(din_c),
    .rdata(rd_c), .rdata_valid(rv_c)
  );

  always_comb begin
    o_ready = rdy_a; o_rs = rso_a; o_rw = rwo_a; o_en = en_a;
    o_dout = {4'h0, dout_a}; o_rdata = rd_a; o_rv = rv_a;
    case (sel)
      1: begin
        o_ready = rdy_b; o_rs = rso_b; o_rw = rwo_b; o_en = en_b;
        o_dout = dout_b; o_rdata = rd_b; o_rv = rv_b;
      end
      2: begin
        o_ready = rdy_c; o_rs = rso_c; o_rw = rwo_c; o_en = en_c;
        o_dout = {4'h0, dout_c}; o_rdata = rd_c; o_rv = rv_c;
      end
      default: ;
    endcase
  end

  function automatic void get_timing(input int s, output int n, output int sc, output int pc,
                                     output int hc, output int gc);
    case (s)
      1:       begin n = 1; sc = 2; pc = 4; hc = 2; gc = 3; end
      2:       begin n = 2; sc = 1; pc = 1; hc = 1; gc = 0; end
      default: begin n = 2; sc = 2; pc = 4; hc = 2; gc = 3; end
    endcase
  endfunction

  task automatic wait_ready(input int s, output bit ok);
    int wt;
    sel = s;
    #1;
    wt = 0;
    while (!o_ready && wt < 100) begin
      @(negedge clk);
      #1;
      wt++;
    end
    ok = (o_ready === 1'b1);
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL idle_wait sel=%0d: ready=%b, required 1", s, o_ready);
    end
  endtask

  // One byte through instance s; expectations come from the phase lengths, not the RTL.
  task automatic run_byte(input int s, input logic [7:0] b, input logic rsv, input logic rwv,
                          input logic [7:0] rb, input bit noise);
    int n, sc, pc, hc, gc, busy, xfer, bad_rs, bad_rw, vcnt, first_bad;
    bit ok;
    logic prev_en, exp_rw;
    logic [7:0] vdata, nib;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    get_timing(s, n, sc, pc, hc, gc);
    wait_ready(s, ok);
    if (!ok) return;
    rs = rsv; rw = rwv; datain = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy = 0; xfer = 0; prev_en = 1'b0; bad_rs = 0; bad_rw = 0; vcnt = 0; vdata = '0;
    exp_rw = RB ? rwv : 1'b0;
    while (!o_ready && busy < 200) begin
      busy++;
      if (o_en && !prev_en) begin
        xfer++;
        din_a = (xfer == 1) ? rb[7:4] : rb[3:0];
        din_c = din_a;
        din_b = rb;
      end
      prev_en = o_en;
      got_q.push_back({o_en, o_dout});
      if (o_rs !== rsv) bad_rs++;
      if (o_rw !== exp_rw) bad_rw++;
      if (o_rv === 1'b1) begin vcnt++; vdata = o_rdata; end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        datain = 8'($urandom);
        rs = 1'($urandom_range(0, 1));
        rw = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (o_rv === 1'b1) begin vcnt++; vdata = o_rdata; end

    nib = '0;
    for (int k = 0; k < n; k++) begin
      nib = (n == 1) ? b : ((k == 0) ? {4'h0, b[7:4]} : {4'h0, b[3:0]});
      repeat (sc) exp_q.push_back({1'b0, nib});
      repeat (pc) exp_q.push_back({1'b1, nib});
      repeat (hc) exp_q.push_back({1'b0, nib});
    end
    repeat (gc) exp_q.push_back({1'b0, nib});

    tests_run++;
    if (busy !== n * (sc + pc + hc) + gc) begin
      tests_failed++;
      $display("FAIL busy_len sel=%0d byte=%h: got %0d cycles, required %0d", s, b, busy,
               n * (sc + pc + hc) + gc);
    end
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first_bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first_bad = i;
    if (got_q.size() != exp_q.size() && first_bad < 0) first_bad = exp_q.size();
    tests_run++;
    if (first_bad >= 0) begin
      tests_failed++;
      $display("FAIL bus_trace sel=%0d byte=%h: cycle %0d got en/data %h, required %h", s, b,
               first_bad, (first_bad < got_q.size()) ? got_q[first_bad] : 9'h1ff,
               (first_bad < exp_q.size()) ? exp_q[first_bad] : 9'h1ff);
    end
    tests_run++;
    if (bad_rs != 0) begin
      tests_failed++;
      $display("FAIL rs_hold sel=%0d: %0d cycles rs_out differed, required rs_out=%b", s, bad_rs, rsv);
    end
    tests_run++;
    if (bad_rw != 0) begin
      tests_failed++;
      $display("FAIL rw_hold sel=%0d: %0d cycles rw_out differed, required rw_out=%b", s, bad_rw, exp_rw);
    end
    tests_run++;
    if (o_en !== 1'b0 || o_dout !== nib) begin
      tests_failed++;
      $display("FAIL idle_hold sel=%0d: en=%b data=%h, required en=0 data=%h", s, o_en, o_dout, nib);
    end
    tests_run++;
    if (vcnt != ((RB && rwv) ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL rvalid_count sel=%0d: got %0d pulses, required %0d", s, vcnt, (RB && rwv) ? 1 : 0);
    end
    if (RB && rwv) begin
      tests_run++;
      if (vdata !== rb) begin
        tests_failed++;
        $display("FAIL rdata sel=%0d: got %h, required %h", s, vdata, rb);
      end
    end else if (!RB) begin
      tests_run++;
      if (o_rdata !== 8'h00) begin
        tests_failed++;
        $display("FAIL rdata_tied sel=%0d: got %h, required 00", s, o_rdata);
      end
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      tests_run++;
      if (o_ready !== 1'b1 || o_en !== 1'b0 || o_rs !== 1'b0 || o_rw !== 1'b0 ||
          o_dout !== 8'h00 || o_rdata !== 8'h00 || o_rv !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state sel=%0d: rdy=%b en=%b rs=%b rw=%b data=%h rd=%h rv=%b, required 1 0 0 0 00 00 0",
                 s, o_ready, o_en, o_rs, o_rw, o_dout, o_rdata, o_rv);
      end
    end
  endtask

  task automatic test_nibble_a5;
    run_byte(0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_byte_3c;
    run_byte(1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_min_timing;
    run_byte(2, 8'hD7, 1'b1, 1'b0, 8'h00, 1'b0);
    run_byte(2, 8'h28, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int acc, run, bad_gap, stay;
    bit ok, seq_ok;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    wait_ready(0, ok);
    if (!ok) return;
    acc = 0; run = 0; bad_gap = 0;
    rs = 1'b0; rw = 1'b0; datain = bytes[0]; start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (o_ready) begin
        run++;
        if (start) begin
          if (acc > 0 && run != 1) bad_gap++;
          acc++;
        end
      end else begin
        run = 0;
        if (o_en) got_q.push_back(o_dout);
      end
      @(negedge clk);
      if (acc < 3) datain = bytes[acc];
      else start = 1'b0;
      if (acc == 3 && !start && o_ready) break;
    end
    start = 1'b0;
    stay = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_ready) stay++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (4) exp_q.push_back({4'h0, bytes[k][7:4]});
      repeat (4) exp_q.push_back({4'h0, bytes[k][3:0]});
    end
    seq_ok = (got_q.size() == exp_q.size());
    for (int i = 0; i < exp_q.size() && seq_ok; i++) if (got_q[i] !== exp_q[i]) seq_ok = 0;
    tests_run++;
    if (acc != 3) begin
      tests_failed++;
      $display("FAIL b2b_accepts: got %0d, required 3", acc);
    end
    tests_run++;
    if (bad_gap != 0) begin
      tests_failed++;
      $display("FAIL b2b_ready_gap: %0d gaps not one cycle, required 0", bad_gap);
    end
    tests_run++;
    if (!seq_ok) begin
      tests_failed++;
      $display("FAIL b2b_bus_data: got %0d enable-high samples, required %0d matching 0/1,0/2,0/3", got_q.size(), exp_q.size());
    end
    tests_run++;
    if (stay != 5) begin
      tests_failed++;
      $display("FAIL b2b_no_extra: ready high %0d of 5 cycles, required 5", stay);
    end
  endtask

  task automatic test_reset_mid_pulse;
    int cnt;
    bit ok;
    wait_ready(0, ok);
    if (!ok) return;
    rs = 1'b1; rw = 1'b0; datain = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (o_en) cnt++;
      if (cnt == 2) break;
      @(negedge clk);
    end
    tests_run++;
    if (cnt != 2) begin
      tests_failed++;
      $display("FAIL rst_reach_pulse: saw %0d enable-high cycles, required 2", cnt);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (en_a !== 1'b0 || rdy_a !== 1'b1 || dout_a !== 4'h0 || rso_a !== 1'b0 ||
        rwo_a !== 1'b0 || rd_a !== 8'h00 || rv_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_pulse: en=%b rdy=%b data=%h rs=%b rw=%b rd=%h rv=%b, required 0 1 0 0 0 00 0",
               en_a, rdy_a, dout_a, rso_a, rwo_a, rd_a, rv_a);
    end
    @(negedge clk);
    rst = 1'b0;
    run_byte(0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_ignore_busy;
    run_byte(0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1);
    run_byte(1, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_readback;
    run_byte(0, 8'h42, 1'b0, 1'b1, 8'h96, 1'b0);
    run_byte(2, 8'h00, 1'b1, 1'b1, 8'hE1, 1'b0);
    run_byte(1, 8'h11, 1'b0, 1'b1, 8'h7B, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      run_byte(int'($urandom_range(0, 2)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rs = 1'b0; rw = 1'b0; datain = '0; sel = 0;
    din_a = '0; din_b = '0; din_c = '0;
    repeat (3) @(negedge clk);
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_nibble_a5;
    test_byte_3c;
    test_min_timing;
    test_back_to_back;
    test_reset_mid_pulse;
    test_ignore_busy;
    test_readback;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
